companion_vitals: RTL and testbench

COMPANION_VITALS -- requirements
Module: companion_vitals

---
 rtl/companion_vitals.sv | 153 +++++++++++++++
 tb/tb_companion_vitals.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/companion_vitals.sv
// Virtual-pet vitals: a one-second prescaler drives periodic stat decay, and
// rate-limited player actions push the stats back; mood follows registered health.
module companion_vitals #(
  parameter int CLOCK_FREQ    = 50_000_000,
  parameter int STAT_W        = 8,
  parameter int STAT_MAX      = 100,
  parameter int DECAY_SECS    = 5,
  parameter int BOOST         = 20,
  parameter int COOLDOWN_SECS = 2,
  parameter int SICK_THRESH   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act_valid,
  input  logic [1:0]        act_code,
  output logic              act_ready,
  output logic [STAT_W-1:0] hunger,
  output logic [STAT_W-1:0] happiness,
  output logic [STAT_W-1:0] clean,
  output logic [STAT_W-1:0] health,
  output logic [1:0]        state,
  output logic              tick
);

  localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam int DW = (DECAY_SECS > 1) ? $clog2(DECAY_SECS) : 1;
  localparam int CW = (COOLDOWN_SECS > 0) ? $clog2(COOLDOWN_SECS + 1) : 1;

  localparam logic [STAT_W:0]   MAX_W      = (STAT_W+1)'(STAT_MAX);
  localparam logic [STAT_W-1:0] MAX_S      = STAT_W'(STAT_MAX);
  localparam logic [STAT_W:0]   ONE_W      = (STAT_W+1)'(1);
  localparam logic [STAT_W:0]   BOOST_W    = (STAT_W+1)'(BOOST);
  localparam logic [STAT_W:0]   THRESH_W   = (STAT_W+1)'(SICK_THRESH);
  localparam logic [STAT_W:0]   HUNGER_BAD = (STAT_W+1)'(STAT_MAX - SICK_THRESH);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_SICK  = 2'd1,
    ST_DEAD  = 2'd2
  } mood_e;

  // Handshake: an action is taken on a rising edge where act_valid && act_ready;
  // act_ready never depends on act_valid, and refused requests are dropped.

  logic [PW-1:0]     presc_q, presc_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [CW-1:0]     cd_q, cd_d;
  logic [STAT_W-1:0] hunger_q, hunger_d;
  logic [STAT_W-1:0] happy_q, happy_d;
  logic [STAT_W-1:0] clean_q, clean_d;
  logic [STAT_W-1:0] health_q, health_d;
  mood_e             state_q, state_d;

  logic at_wrap, decay, accept, bad;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + b;
    return (s > MAX_W) ? MAX_S : s[STAT_W-1:0];
  endfunction

  function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} - b;
    return ({1'b0, a} < b) ? '0 : s[STAT_W-1:0];
  endfunction

  assign at_wrap   = (presc_q == PW'(CLOCK_FREQ - 1));
  assign tick      = !rst && at_wrap;
  assign decay     = tick && (dcnt_q == DW'(DECAY_SECS - 1));
  assign act_ready = !rst && (state_q != ST_DEAD) && (cd_q == '0);
  assign accept    = act_valid && act_ready;
  assign bad       = ({1'b0, hunger_q} >= HUNGER_BAD) ||
                     ({1'b0, happy_q} <= THRESH_W) ||
                     ({1'b0, clean_q} <= THRESH_W);

  always_comb begin
    presc_d  = at_wrap ? '0 : presc_q + PW'(1);
    dcnt_d   = dcnt_q;
    cd_d     = cd_q;
    hunger_d = hunger_q;
    happy_d  = happy_q;
    clean_d  = clean_q;
    health_d = health_q;
    state_d  = state_q;

    if (tick) dcnt_d = (dcnt_q == DW'(DECAY_SECS - 1)) ? '0 : dcnt_q + DW'(1);

    if (state_q != ST_DEAD) begin
      // Decay lands first so a same-edge action works on the decayed values.
      if (decay) begin
        hunger_d = sat_add(hunger_q, ONE_W);
        happy_d  = sat_sub(happy_q, ONE_W);
        clean_d  = sat_sub(clean_q, ONE_W);
        health_d = bad ? sat_sub(health_q, ONE_W) : sat_add(health_q, ONE_W);
      end
      if (accept) begin
        case (act_code)
          2'd0:    hunger_d = sat_sub(hunger_d, BOOST_W);
          2'd1:    happy_d  = sat_add(happy_d, BOOST_W);
          2'd2:    clean_d  = MAX_S;
          default: if (state_q == ST_SICK) health_d = sat_add(health_d, BOOST_W);
        endcase
        cd_d = CW'(COOLDOWN_SECS);
      end else if (tick && cd_q != '0) begin
        cd_d = cd_q - CW'(1);
      end
    end

    case (state_q)
      ST_ALIVE: begin
        if (health_q == '0)                     state_d = ST_DEAD;
        else if ({1'b0, health_q} <= THRESH_W)  state_d = ST_SICK;
      end
      ST_SICK: begin
        if (health_q == '0)                     state_d = ST_DEAD;
        else if ({1'b0, health_q} > THRESH_W)   state_d = ST_ALIVE;
      end
      default: state_d = ST_DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      dcnt_q   <= '0;
      cd_q     <= '0;
      hunger_q <= '0;
      happy_q  <= MAX_S;
      clean_q  <= MAX_S;
      health_q <= MAX_S;
      state_q  <= ST_ALIVE;
    end else begin
      presc_q  <= presc_d;
      dcnt_q   <= dcnt_d;
      cd_q     <= cd_d;
      hunger_q <= hunger_d;
      happy_q  <= happy_d;
      clean_q  <= clean_d;
      health_q <= health_d;
      state_q  <= state_d;
    end
  end

  assign hunger    = hunger_q;
  assign happiness = happy_q;
  assign clean     = clean_q;
  assign health    = health_q;
  assign state     = state_q;

endmodule

// File: tb/tb_companion_vitals.sv
// Bench for companion_vitals: directed scenarios plus random actions, each cycle
// compared against a cycle-count based behavioural model of the pet.
module tb_companion_vitals;
  localparam int CF  = 4;
  localparam int SW  = 8;
  localparam int MAX = 100;
  localparam int DS  = 2;
  localparam int BST = 20;
  localparam int CD  = 2;
  localparam int ST  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          act_valid = 1'b0;
  logic [1:0]    act_code = 2'd0;
  logic          act_ready;
  logic [SW-1:0] hunger, happiness, clean, health;
  logic [1:0]    state;
  logic          tick;

  companion_vitals #(
    .CLOCK_FREQ(CF), .STAT_W(SW), .STAT_MAX(MAX), .DECAY_SECS(DS),
    .BOOST(BST), .COOLDOWN_SECS(CD), .SICK_THRESH(ST)
  ) dut (
    .clk(clk), .rst(rst), .act_valid(act_valid), .act_code(act_code),
    .act_ready(act_ready), .hunger(hunger), .happiness(happiness),
    .clean(clean), .health(health), .state(state), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: stats as plain ints; time measured as edges since the reset edge.
  int m_h, m_p, m_c, m_hl, m_st, m_cd, m_cyc, m_ticks, n_dec;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_p = MAX; m_c = MAX; m_hl = MAX; m_st = 0;
    m_cd = 0; m_cyc = 0; m_ticks = 0; n_dec = 0;
  endtask

  function automatic bit decay_next();
    return ((m_cyc % CF) == CF - 1) && (((m_cyc / CF) % DS) == DS - 1);
  endfunction

  task automatic model_edge(input bit r, input bit v, input int code);
    bit tk, dec, rdy, bad;
    int old_h, old_st;
    if (r) begin
      model_reset();
      return;
    end
    tk  = (m_cyc % CF) == CF - 1;
    dec = decay_next();
    m_cyc++;
    if (tk) m_ticks++;
    old_h  = m_hl;
    old_st = m_st;
    if (old_st != 2) begin
      rdy = (m_cd == 0);
      if (dec) begin
        n_dec++;
        bad  = (m_h >= MAX - ST) || (m_p <= ST) || (m_c <= ST);
        m_h  = imin(m_h + 1, MAX);
        m_p  = imax(m_p - 1, 0);
        m_c  = imax(m_c - 1, 0);
        m_hl = bad ? imax(m_hl - 1, 0) : imin(m_hl + 1, MAX);
      end
      if (v && rdy) begin
        case (code)
          0: m_h = imax(m_h - BST, 0);
          1: m_p = imin(m_p + BST, MAX);
          2: m_c = MAX;
          default: if (old_st == 1) m_hl = imin(m_hl + BST, MAX);
        endcase
        m_cd = CD;
      end else if (tk && m_cd > 0) begin
        m_cd--;
      end
      if (old_h == 0)                   m_st = 2;
      else if (old_st == 0 && old_h <= ST) m_st = 1;
      else if (old_st == 1 && old_h > ST)  m_st = 0;
    end
  endtask

  task automatic check_all();
    chk("hunger", 32'(hunger), 32'(m_h));
    chk("happiness", 32'(happiness), 32'(m_p));
    chk("clean", 32'(clean), 32'(m_c));
    chk("health", 32'(health), 32'(m_hl));
    chk("state", 32'(state), 32'(m_st));
    chk("act_ready", 32'(act_ready), 32'(!rst && m_st != 2 && m_cd == 0));
    chk("tick", 32'(tick), 32'(!rst && (m_cyc % CF) == CF - 1));
  endtask

  task automatic step(input bit v, input logic [1:0] code);
    act_valid = v;
    act_code  = code;
    @(posedge clk);
    model_edge(rst, v, int'(code));
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    rst = 1'b0;
    #1;
    check_all();
    chk("ready_after_release", 32'(act_ready), 32'd1);
  endtask

  task automatic idle_until_decays(input int target);
    for (int i = 0; i < 4000 && n_dec < target; i++) step(1'b0, 2'($urandom_range(0, 3)));
    chk("decay_count", 32'(n_dec), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Reset defaults
    do_reset();
    chk("rst_hunger", 32'(hunger), 32'd0);
    chk("rst_health", 32'(health), 32'd100);

    // First decay lands after 8 cycles
    for (int i = 0; i < 8; i++) step(1'b0, 2'($urandom_range(0, 3)));
    chk("decay1_hunger", 32'(hunger), 32'd1);
    chk("decay1_happy", 32'(happiness), 32'd99);
    chk("decay1_health", 32'(health), 32'd100);

    // Heal while ALIVE: accepted, no effect, cooldown loaded
    do_reset();
    step(1'b1, 2'd3);
    chk("heal_alive_health", 32'(health), 32'd100);
    chk("heal_alive_ready", 32'(act_ready), 32'd0);

    // Feed with hunger 5, then cooldown behaviour
    do_reset();
    idle_until_decays(5);
    chk("pre_feed_hunger", 32'(hunger), 32'd5);
    step(1'b1, 2'd0);
    chk("feed_hunger", 32'(hunger), 32'd0);
    begin
      int t0, hp;
      t0 = m_ticks;
      hp = m_p;
      step(1'b1, 2'd1);
      chk("play_in_cooldown", 32'(happiness), 32'(hp));
      for (int i = 0; i < 40 && (m_ticks - t0) < 2; i++) begin
        chk("cooldown_ready_low", 32'(act_ready), 32'd0);
        step(1'b0, 2'd0);
      end
      chk("cooldown_ticks", 32'(m_ticks - t0), 32'd2);
      chk("cooldown_done_ready", 32'(act_ready), 32'd1);
    end

    // Feed on a decay edge with hunger 30
    do_reset();
    idle_until_decays(30);
    chk("pre_sim_hunger", 32'(hunger), 32'd30);
    for (int i = 0; i < 20 && !decay_next(); i++) step(1'b0, 2'd0);
    step(1'b1, 2'd0);
    chk("sim_hunger", 32'(hunger), 32'd11);

    // Reset in the middle of a cooldown
    step(1'b1, 2'd2);
    do_reset();

    // Neglect to death
    do_reset();
    idle_until_decays(81);
    chk("neglect81_health", 32'(health), 32'd99);
    idle_until_decays(160);
    chk("neglect160_health", 32'(health), 32'd20);
    step(1'b0, 2'd0);
    chk("neglect_sick", 32'(state), 32'd1);
    idle_until_decays(180);
    chk("neglect180_health", 32'(health), 32'd0);
    step(1'b0, 2'd0);
    chk("neglect_dead", 32'(state), 32'd2);
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    chk("dead_hunger", 32'(hunger), 32'd100);
    chk("dead_happy", 32'(happiness), 32'd0);
    chk("dead_health", 32'(health), 32'd0);
    chk("dead_ready", 32'(act_ready), 32'd0);

    // Heal when SICK at health 15 (rst straight out of DEAD)
    do_reset();
    idle_until_decays(165);
    chk("pre_heal_health", 32'(health), 32'd15);
    chk("pre_heal_state", 32'(state), 32'd1);
    step(1'b1, 2'd3);
    chk("heal_health", 32'(health), 32'd35);
    step(1'b0, 2'd0);
    chk("heal_state", 32'(state), 32'd0);

    // Random actions against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
